// File: rtl/kf_mem_bank.sv
// kf_mem_bank: DEPTH x W register bank with valid bits, zero-sweep init FSM
// and NACC saturating accumulator channels.
module kf_mem_bank #(
    parameter int W       = 24,
    parameter int DEPTH   = 40,
    parameter int ADDRW   = 6,
    parameter int NACC    = 2,
    parameter int FORWARD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_req,
    output logic                 init_busy,
    input  logic                 we,
    input  logic [ADDRW-1:0]     waddr,
    input  logic [W-1:0]         wdata,
    input  logic [ADDRW-1:0]     raddr_a,
    input  logic [ADDRW-1:0]     raddr_b,
    output logic [W-1:0]         rdata_a,
    output logic [W-1:0]         rdata_b,
    output logic                 rvalid_a,
    output logic                 rvalid_b,
    input  logic [2*NACC-1:0]    acc_op,
    input  logic [W*NACC-1:0]    acc_d,
    output logic [W*NACC-1:0]    acc_q,
    output logic [NACC-1:0]      acc_ovf
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [ADDRW:0]   DEPTH_L = (ADDRW+1)'(DEPTH);
    localparam logic [ADDRW-1:0] LAST    = ADDRW'(DEPTH-1);

    state_t           state, state_nx;
    logic [ADDRW-1:0] ptr, ptr_nx;
    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic             wr_en;
    logic             wr_val;
    logic [ADDRW-1:0] wr_addr;
    logic [W-1:0]     wr_data;

    // Single effective write per cycle: the sweep owns the port while active.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        wr_en    = 1'b0;
        wr_val   = 1'b1;
        wr_addr  = waddr;
        wr_data  = wdata;
        unique case (state)
            IDLE: begin
                wr_en = we && ({1'b0, waddr} < DEPTH_L);
                if (init_req) begin
                    state_nx = SWEEP;
                    ptr_nx   = '0;
                end
            end
            SWEEP: begin
                wr_en   = 1'b1;
                wr_val  = 1'b0;
                wr_addr = ptr;
                wr_data = '0;
                ptr_nx  = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end
            end
            default: ;
        endcase
        if (rst) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            if (wr_en) valid[wr_addr] <= wr_val;
        end
    end

    // Data bank has no reset; rst already suppresses wr_en.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    function automatic logic [W:0] rd(input logic [ADDRW-1:0] a);
        if ({1'b0, a} >= DEPTH_L) return '0;
        if (FORWARD != 0 && wr_en && a == wr_addr) return {wr_val, wr_data};
        return {valid[a], mem[a]};
    endfunction

    assign {rvalid_a, rdata_a} = rd(raddr_a);
    assign {rvalid_b, rdata_b} = rd(raddr_b);
    assign init_busy = (state == SWEEP);

    for (genvar k = 0; k < NACC; k++) begin : g_acc
        logic [W-1:0] acc;
        logic [W-1:0] d;
        logic [1:0]   op;
        logic [W:0]   sum;
        logic         sat;
        logic         ovf;

        assign d   = acc_d[k*W +: W];
        assign op  = acc_op[2*k +: 2];
        assign sum = {acc[W-1], acc} + {d[W-1], d};
        assign sat = sum[W] ^ sum[W-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                unique case (op)
                    2'b01: acc <= d;
                    2'b10: begin
                        if (sat) begin
                            acc <= sum[W] ? {1'b1, {(W-1){1'b0}}}
                                          : {1'b0, {(W-1){1'b1}}};
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum[W-1:0];
                        end
                    end
                    2'b11: begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        assign acc_q[k*W +: W] = acc;
        assign acc_ovf[k]      = ovf;
    end

endmodule

// File: tb/tb_kf_mem_bank.sv
// Scoreboard bench for kf_mem_bank: a behavioural model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_kf_mem_bank;

    localparam int W     = 24;
    localparam int DEPTH = 40;
    localparam int ADDRW = 6;
    localparam int NACC  = 2;
    localparam longint MAXV = (longint'(1) << (W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (W-1));

    logic                 clk = 1'b0;
    logic                 rst, init_req, init_busy, we;
    logic [ADDRW-1:0]     waddr, raddr_a, raddr_b;
    logic [W-1:0]         wdata, rdata_a, rdata_b;
    logic                 rvalid_a, rvalid_b;
    logic [2*NACC-1:0]    acc_op;
    logic [W*NACC-1:0]    acc_d, acc_q;
    logic [NACC-1:0]      acc_ovf;

    kf_mem_bank #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW),
                  .NACC(NACC), .FORWARD(1)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .acc_op(acc_op), .acc_d(acc_d), .acc_q(acc_q), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]      da, db;
        logic              va, vb, ka, kb, busy;
        logic [W*NACC-1:0] q;
        logic [NACC-1:0]   ovf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_mem [DEPTH];
    bit           m_val [DEPTH];
    bit           m_known [DEPTH];
    bit           m_busy;
    int           m_idx;
    logic [W-1:0] m_acc [NACC];
    bit           m_ovf [NACC];
    bit           model_ok = 1'b0;

    function automatic longint sx(input logic [W-1:0] v);
        return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("init_busy", 64'(init_busy), 64'(e.busy));
            chk("rvalid_a", 64'(rvalid_a), 64'(e.va));
            chk("rvalid_b", 64'(rvalid_b), 64'(e.vb));
            if (e.ka) chk("rdata_a", 64'(rdata_a), 64'(e.da));
            if (e.kb) chk("rdata_b", 64'(rdata_b), 64'(e.db));
            chk("acc_q", 64'(acc_q), 64'(e.q));
            chk("acc_ovf", 64'(acc_ovf), 64'(e.ovf));
        end
    end

    task automatic idle();
        rst = 0; init_req = 0; we = 0; acc_op = '0;
    endtask

    task automatic rd_model(input int a, input bit fe, input int fa,
                            input logic [W-1:0] fd, input bit fv,
                            output logic [W-1:0] d, output logic v,
                            output logic k);
        if (a >= DEPTH) begin
            d = '0; v = 0; k = 1;
        end else if (fe && a == fa) begin
            d = fd; v = fv; k = 1;
        end else begin
            d = m_mem[a]; v = m_val[a]; k = m_known[a];
        end
    endtask

    task automatic update_model();
        if (rst) begin
            m_busy = 0; m_idx = 0;
            for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
            for (int k = 0; k < NACC; k++) begin
                m_acc[k] = '0; m_ovf[k] = 0;
            end
            model_ok = 1'b1;
            return;
        end
        if (m_busy) begin
            m_mem[m_idx] = '0; m_val[m_idx] = 0; m_known[m_idx] = 1;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 0;
        end else begin
            if (we && int'(waddr) < DEPTH) begin
                m_mem[waddr] = wdata; m_val[waddr] = 1; m_known[waddr] = 1;
            end
            if (init_req) begin
                m_busy = 1; m_idx = 0;
            end
        end
        for (int k = 0; k < NACC; k++) begin
            logic [1:0]   op;
            logic [W-1:0] d;
            longint       s;
            op = acc_op[2*k +: 2];
            d  = acc_d[k*W +: W];
            case (op)
                2'b01: m_acc[k] = d;
                2'b10: begin
                    s = sx(m_acc[k]) + sx(d);
                    if (s > MAXV) begin
                        s = MAXV; m_ovf[k] = 1;
                    end else if (s < MINV) begin
                        s = MINV; m_ovf[k] = 1;
                    end
                    m_acc[k] = s[W-1:0];
                end
                2'b11: begin
                    m_acc[k] = '0; m_ovf[k] = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        if (model_ok) begin
            exp_t e;
            bit fe, fv;
            int fa;
            logic [W-1:0] fd;
            fe = !rst && (m_busy || (we && int'(waddr) < DEPTH));
            fa = m_busy ? m_idx : int'(waddr);
            fd = m_busy ? '0 : wdata;
            fv = !m_busy;
            rd_model(int'(raddr_a), fe, fa, fd, fv, e.da, e.va, e.ka);
            rd_model(int'(raddr_b), fe, fa, fd, fv, e.db, e.vb, e.kb);
            e.busy = m_busy;
            for (int k = 0; k < NACC; k++) begin
                e.q[k*W +: W] = m_acc[k];
                e.ovf[k] = m_ovf[k];
            end
            sb.push_back(e);
        end
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic fill();
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            we = 1; waddr = ADDRW'(a); wdata = W'($urandom);
            raddr_a = ADDRW'(a); raddr_b = ADDRW'($urandom_range(0, 63));
            step();
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            raddr_a = ADDRW'(a);
            raddr_b = ADDRW'((a + 20) % DEPTH);
            step();
        end
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return W'(32'h7FFF00 + $urandom_range(0, 255));
            1: return W'(32'h800000 + $urandom_range(0, 255));
            2: return W'($urandom_range(0, 255));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        idle();
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; acc_d = '0;
        rst = 1; step(); rst = 1; step();
        idle(); raddr_a = 6'd3; raddr_b = 6'd39; step();

        idle(); we = 1; waddr = 6'd5; wdata = 24'h123456;
        raddr_a = 6'd5; raddr_b = 6'd6; step();
        idle(); raddr_a = 6'd5; step();

        idle(); we = 1; waddr = 6'd40; wdata = 24'hABCDEF;
        raddr_a = 6'd40; raddr_b = 6'd5; step();
        idle(); raddr_a = 6'd40; raddr_b = 6'd63; step();

        fill();
        idle(); init_req = 1; step();
        for (int i = 0; i < DEPTH + 3; i++) begin
            idle();
            we = 1'($urandom); waddr = ADDRW'($urandom_range(0, 45));
            wdata = W'($urandom); init_req = (i == 7);
            raddr_a = ADDRW'($urandom_range(0, 45));
            raddr_b = ADDRW'(i % DEPTH);
            step();
        end
        read_all();

        idle(); acc_op = 4'b0101; acc_d = {24'h000111, 24'h7FFFF0}; step();
        idle(); acc_op = 4'b0010; acc_d = {24'h000222, 24'h000020}; step();
        idle(); acc_op = 4'b0001; acc_d = {24'h000333, 24'h000000}; step();
        idle(); acc_op = 4'b0011; step();
        idle(); step();
        idle(); acc_op = 4'b0100; acc_d = {24'h800010, 24'h0}; step();
        idle(); acc_op = 4'b1000; acc_d = {24'hFFFFE0, 24'h0}; step();
        idle(); step();

        fill();
        idle(); init_req = 1; step();
        for (int i = 0; i < 10; i++) begin
            idle(); raddr_a = ADDRW'(i); step();
        end
        idle(); rst = 1; we = 1; waddr = 6'd20; wdata = 24'h55AA55;
        init_req = 1; raddr_a = 6'd20; step();
        read_all();

        for (int i = 0; i < 2000; i++) begin
            idle();
            rst      = ($urandom_range(0, 199) == 0);
            init_req = ($urandom_range(0, 59) == 0);
            we       = 1'($urandom);
            waddr    = ADDRW'($urandom_range(0, 47));
            wdata    = W'($urandom);
            raddr_a  = ($urandom_range(0, 3) == 0) ? waddr
                                                   : ADDRW'($urandom_range(0, 63));
            raddr_b  = ADDRW'($urandom_range(0, 47));
            acc_op   = 4'($urandom);
            acc_d    = {rnd_operand(), rnd_operand()};
            step();
        end

        idle();
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
